// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard control for a 5-stage pipeline (IF, ID, EX, MEM, WB). It reads the
// register and control fields carried by the IF_ID, ID_EX, EX_MEM and MEM_WB
// pipeline registers. It drives back the PC/IF_ID enables, the per-register
// flush (bubble) controls and the EX-stage operand forwarding selects.
//
// Handled hazards:
//   - load-use: the load sits in EX and the instruction in ID reads its
//     destination. The front end stalls for LOAD_STALL_CYC cycles while
//     bubbles go into ID_EX.
//   - taken branch resolved in MEM: IF_ID, ID_EX and EX_MEM are squashed
//     together, followed by a single BR_FLUSH recovery cycle.
//   - XZR (X31) never creates a dependency and is never forwarded.
//
// Parameters:
//   LOAD_STALL_CYC  bubbles per load-use hazard (legal range 1..4)
//   CNT_W           width of the performance counters
//
// Configuration macro:
//   HAZARD_PERF_CNT_EN  when defined, stall_cnt/flush_cnt count events.
//                       When undefined, no counter logic is built and both
//                       ports read 0.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   rn_id, rm_id         ID-stage source registers
//   uses_rm_id           ID instruction reads rm_id
//   mem_read_ex, rw_ex   ID_EX MemRead and destination register
//   rn_ex, rm_ex         EX-stage source registers (forwarding)
//   regwrite_mem, rw_mem EX_MEM RegWrite and destination register
//   regwrite_wb, rw_wb   MEM_WB RegWrite and destination register
//   br_taken_mem         branch in MEM resolved taken
//   pc_en, if_id_en      PC / IF_ID load enables
//   if_id_flush          load NOP into IF_ID
//   id_ex_flush          zero control fields into ID_EX
//   ex_mem_flush         zero control fields into EX_MEM
//   fwd_a, fwd_b         00 regfile, 10 EX_MEM result, 01 MEM_WB writeback
//   stall_cnt            load-use bubble cycles
//   flush_cnt            taken-branch squash events
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rn_id,
    input  logic [4:0]       rm_id,
    input  logic             uses_rm_id,
    input  logic             mem_read_ex,
    input  logic [4:0]       rw_ex,
    input  logic [4:0]       rn_ex,
    input  logic [4:0]       rm_ex,
    input  logic             regwrite_mem,
    input  logic [4:0]       rw_mem,
    input  logic             regwrite_wb,
    input  logic [4:0]       rw_wb,
    input  logic             br_taken_mem,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [4:0] XZR         = 5'd31;
    localparam bit         MULTI_STALL = (LOAD_STALL_CYC > 1);
    // Remaining LD_STALL cycles after the first bubble is issued from RUN.
    localparam logic [1:0] CNT_INIT    = MULTI_STALL ? 2'(LOAD_STALL_CYC - 2) : 2'd0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] cnt_r;
    logic [1:0] cnt_nxt_s;
    logic       ld_haz_s;

    logic       pc_en_s;
    logic       if_id_en_s;
    logic       if_id_flush_s;
    logic       id_ex_flush_s;
    logic       ex_mem_flush_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // Operand select for one EX source. The younger EX_MEM result has
    // priority over MEM_WB, and X31 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       wr_mem,
        input logic [4:0] dst_mem,
        input logic       wr_wb,
        input logic [4:0] dst_wb
    );
        logic [1:0] sel;
        if (wr_mem && (dst_mem != XZR) && (dst_mem == src)) begin
            sel = FWD_MEM;
        end else if (wr_wb && (dst_wb != XZR) && (dst_wb == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Load-use detection: the load in EX writes a register the ID instruction reads.
    always_comb begin
        ld_haz_s = 1'b0;
        if (mem_read_ex && (rw_ex != XZR)) begin
            ld_haz_s = (rw_ex == rn_id) || (uses_rm_id && (rw_ex == rm_id));
        end else begin
            ld_haz_s = 1'b0;
        end
    end

    // Next-state and control outputs; reset forces a safe, fully flushed front end.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        pc_en_s        = 1'b1;
        if_id_en_s     = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        fwd_a_s        = FWD_RF;
        fwd_b_s        = FWD_RF;

        if (!reset) begin
            pc_en_s        = 1'b0;
            if_id_en_s     = 1'b0;
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            state_nxt_s    = RUN;
            cnt_nxt_s      = 2'd0;
        end else begin
            fwd_a_s = fwd_sel(rn_ex, regwrite_mem, rw_mem, regwrite_wb, rw_wb);
            fwd_b_s = fwd_sel(rm_ex, regwrite_mem, rw_mem, regwrite_wb, rw_wb);

            if (br_taken_mem) begin
                // Squash everything younger than the branch. The PC keeps
                // loading so the branch target is fetched this cycle.
                if_id_flush_s  = 1'b1;
                id_ex_flush_s  = 1'b1;
                ex_mem_flush_s = 1'b1;
                state_nxt_s    = BR_FLUSH;
                cnt_nxt_s      = 2'd0;
            end else begin
                case (state_r)
                    RUN: begin
                        if (ld_haz_s) begin
                            pc_en_s       = 1'b0;
                            if_id_en_s    = 1'b0;
                            id_ex_flush_s = 1'b1;
                            if (MULTI_STALL) begin
                                state_nxt_s = LD_STALL;
                                cnt_nxt_s   = CNT_INIT;
                            end else begin
                                state_nxt_s = RUN;
                            end
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end
                    LD_STALL: begin
                        // Hazard was committed on entry; hold until the count drains.
                        pc_en_s       = 1'b0;
                        if_id_en_s    = 1'b0;
                        id_ex_flush_s = 1'b1;
                        if (cnt_r == 2'd0) begin
                            state_nxt_s = RUN;
                        end else begin
                            cnt_nxt_s = cnt_r - 2'd1;
                        end
                    end
                    BR_FLUSH: begin
                        // ID holds the NOP from the squash, so ld_haz is meaningless here.
                        state_nxt_s = RUN;
                    end
                    default: begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = 2'd0;
                    end
                endcase
            end
        end
    end

    // State and stall-count register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= RUN;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign pc_en        = pc_en_s;
    assign if_id_en     = if_id_en_s;
    assign if_id_flush  = if_id_flush_s;
    assign id_ex_flush  = id_ex_flush_s;
    assign ex_mem_flush = ex_mem_flush_s;
    assign fwd_a        = fwd_a_s;
    assign fwd_b        = fwd_b_s;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             stall_evt_s;
    logic             flush_evt_s;

    // A bubble cycle is any non-reset cycle with the PC held; a squash is any taken branch.
    assign stall_evt_s = reset & ~pc_en_s;
    assign flush_evt_s = reset & br_taken_mem;

    // Free-running performance counters; they wrap on overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (stall_evt_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_evt_s) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Two instances share all inputs:
// dut1 (LOAD_STALL_CYC=1) and dut3 (LOAD_STALL_CYC=3). Inputs change on the
// falling edge, and the combinational outputs are sampled 1 ns later.
// Expected counter values are masked to zero when the performance counters
// are not built.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] PERF_MASK = {CNT_W{1'b1}};
`else
    localparam logic [CNT_W-1:0] PERF_MASK = {CNT_W{1'b0}};
`endif

    logic       clk;
    logic       reset;
    logic [4:0] rn_id, rm_id, rw_ex, rn_ex, rm_ex, rw_mem, rw_wb;
    logic       uses_rm_id, mem_read_ex, regwrite_mem, regwrite_wb, br_taken_mem;

    logic             pc_en_1, if_id_en_1, if_id_flush_1, id_ex_flush_1, ex_mem_flush_1;
    logic [1:0]       fwd_a_1, fwd_b_1;
    logic [CNT_W-1:0] stall_cnt_1, flush_cnt_1;
    logic             pc_en_3, if_id_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3;
    logic [1:0]       fwd_a_3, fwd_b_3;
    logic [CNT_W-1:0] stall_cnt_3, flush_cnt_3;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .reset(reset), .rn_id(rn_id), .rm_id(rm_id), .uses_rm_id(uses_rm_id),
        .mem_read_ex(mem_read_ex), .rw_ex(rw_ex), .rn_ex(rn_ex), .rm_ex(rm_ex),
        .regwrite_mem(regwrite_mem), .rw_mem(rw_mem), .regwrite_wb(regwrite_wb), .rw_wb(rw_wb),
        .br_taken_mem(br_taken_mem), .pc_en(pc_en_1), .if_id_en(if_id_en_1),
        .if_id_flush(if_id_flush_1), .id_ex_flush(id_ex_flush_1), .ex_mem_flush(ex_mem_flush_1),
        .fwd_a(fwd_a_1), .fwd_b(fwd_b_1), .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(CNT_W)) dut3 (
        .clk(clk), .reset(reset), .rn_id(rn_id), .rm_id(rm_id), .uses_rm_id(uses_rm_id),
        .mem_read_ex(mem_read_ex), .rw_ex(rw_ex), .rn_ex(rn_ex), .rm_ex(rm_ex),
        .regwrite_mem(regwrite_mem), .rw_mem(rw_mem), .regwrite_wb(regwrite_wb), .rw_wb(rw_wb),
        .br_taken_mem(br_taken_mem), .pc_en(pc_en_3), .if_id_en(if_id_en_3),
        .if_id_flush(if_id_flush_3), .id_ex_flush(id_ex_flush_3), .ex_mem_flush(ex_mem_flush_3),
        .fwd_a(fwd_a_3), .fwd_b(fwd_b_3), .stall_cnt(stall_cnt_3), .flush_cnt(flush_cnt_3)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        rn_id = 5'd0; rm_id = 5'd0; uses_rm_id = 1'b0; mem_read_ex = 1'b0; rw_ex = 5'd0;
        rn_ex = 5'd0; rm_ex = 5'd0; regwrite_mem = 1'b0; rw_mem = 5'd0;
        regwrite_wb = 1'b0; rw_wb = 5'd0; br_taken_mem = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0; clear_inputs();
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); clear_inputs();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        regwrite_mem = 1'b1; rw_mem = 5'd7; rn_ex = 5'd7; rm_ex = 5'd7;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_vec++;
            if ({pc_en_3, if_id_en_3} !== 2'b00) begin
                n_err++; $display("FAIL rst_en: got %b want 00", {pc_en_3, if_id_en_3});
            end
            n_vec++;
            if ({if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 3'b111) begin
                n_err++; $display("FAIL rst_flush: got %b want 111", {if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
            end
            n_vec++;
            if ({fwd_a_3, fwd_b_3, fwd_a_1} !== 6'b000000) begin
                n_err++; $display("FAIL rst_fwd: got %b want 000000", {fwd_a_3, fwd_b_3, fwd_a_1});
            end
        end
        n_vec++;
        if ({stall_cnt_3, flush_cnt_3} !== {2*CNT_W{1'b0}}) begin
            n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt_3, flush_cnt_3);
        end
        @(negedge clk); reset = 1'b1; clear_inputs(); #1;
        n_vec++;
        if ({pc_en_1, if_id_en_1, pc_en_3, if_id_en_3} !== 4'b1111) begin
            n_err++; $display("FAIL rst_release_en: got %b want 1111", {pc_en_1, if_id_en_1, pc_en_3, if_id_en_3});
        end
        n_vec++;
        if ({if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 3'b000) begin
            n_err++; $display("FAIL rst_release_flush: got %b want 000", {if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
        end
    endtask

    task automatic test_load_use_single();
        pulse_reset();
        @(negedge clk); mem_read_ex = 1'b1; rw_ex = 5'd3; rn_id = 5'd3; #1;
        n_vec++;
        if ({pc_en_1, if_id_en_1, if_id_flush_1, id_ex_flush_1, ex_mem_flush_1} !== 5'b00010) begin
            n_err++; $display("FAIL lu1_stall: got %b want 00010",
                {pc_en_1, if_id_en_1, if_id_flush_1, id_ex_flush_1, ex_mem_flush_1});
        end
        @(negedge clk); mem_read_ex = 1'b0; #1;
        n_vec++;
        if ({pc_en_1, id_ex_flush_1} !== 2'b10) begin
            n_err++; $display("FAIL lu1_resume: got %b want 10", {pc_en_1, id_ex_flush_1});
        end
        n_vec++;
        if (stall_cnt_1 !== (32'd1 & PERF_MASK)) begin
            n_err++; $display("FAIL lu1_stall_cnt: got %0d want %0d", stall_cnt_1, 32'd1 & PERF_MASK);
        end
        idle(3);
    endtask

    task automatic test_load_use_multi_branch();
        pulse_reset();
        // A, B: hazard held; C: hazard gone but the stall still completes.
        @(negedge clk); mem_read_ex = 1'b1; rw_ex = 5'd3; rn_id = 5'd3; #1;
        n_vec++;
        if ({pc_en_3, id_ex_flush_3} !== 2'b01) begin
            n_err++; $display("FAIL lu3_c1: got %b want 01", {pc_en_3, id_ex_flush_3});
        end
        @(negedge clk); #1;
        n_vec++;
        if ({pc_en_3, id_ex_flush_3} !== 2'b01) begin
            n_err++; $display("FAIL lu3_c2: got %b want 01", {pc_en_3, id_ex_flush_3});
        end
        @(negedge clk); mem_read_ex = 1'b0; #1;
        n_vec++;
        if ({pc_en_3, if_id_en_3, id_ex_flush_3} !== 3'b001) begin
            n_err++; $display("FAIL lu3_c3: got %b want 001", {pc_en_3, if_id_en_3, id_ex_flush_3});
        end
        @(negedge clk); #1;
        n_vec++;
        if ({pc_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 4'b1000) begin
            n_err++; $display("FAIL lu3_done: got %b want 1000", {pc_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
        end
        n_vec++;
        if (stall_cnt_3 !== (32'd3 & PERF_MASK)) begin
            n_err++; $display("FAIL lu3_stall_cnt: got %0d want %0d", stall_cnt_3, 32'd3 & PERF_MASK);
        end
        // Branch taken in the 2nd stall cycle overrides the stall.
        @(negedge clk); mem_read_ex = 1'b1; #1;
        n_vec++;
        if (pc_en_3 !== 1'b0) begin
            n_err++; $display("FAIL br_pre_stall: got %b want 0", pc_en_3);
        end
        @(negedge clk); br_taken_mem = 1'b1; #1;
        n_vec++;
        if ({pc_en_3, if_id_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 5'b11111) begin
            n_err++; $display("FAIL br_squash: got %b want 11111",
                {pc_en_3, if_id_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
        end
        n_vec++;
        if (stall_cnt_3 !== (32'd4 & PERF_MASK)) begin
            n_err++; $display("FAIL br_stall_cnt: got %0d want %0d", stall_cnt_3, 32'd4 & PERF_MASK);
        end
        // BR_FLUSH ignores the still-present hazard.
        @(negedge clk); br_taken_mem = 1'b0; #1;
        n_vec++;
        if ({pc_en_3, if_id_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 5'b11000) begin
            n_err++; $display("FAIL br_flush_state: got %b want 11000",
                {pc_en_3, if_id_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
        end
        // Back in RUN: the hazard is seen again.
        @(negedge clk); #1;
        n_vec++;
        if ({pc_en_3, id_ex_flush_3} !== 2'b01) begin
            n_err++; $display("FAIL br_back_run: got %b want 01", {pc_en_3, id_ex_flush_3});
        end
        idle(3);
        #1;
        n_vec++;
        if (pc_en_3 !== 1'b1) begin
            n_err++; $display("FAIL br_recovered: got %b want 1", pc_en_3);
        end
        n_vec++;
        if ({stall_cnt_3, flush_cnt_3} !== {32'd7 & PERF_MASK, 32'd1 & PERF_MASK}) begin
            n_err++; $display("FAIL br_cnts: got %0d/%0d want %0d/%0d", stall_cnt_3, flush_cnt_3,
                32'd7 & PERF_MASK, 32'd1 & PERF_MASK);
        end
        // Back-to-back taken branches: the squash is applied again from BR_FLUSH.
        @(negedge clk); br_taken_mem = 1'b1; #1;
        n_vec++;
        if ({if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 3'b111) begin
            n_err++; $display("FAIL b2b_sq1: got %b want 111", {if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
        end
        @(negedge clk); #1;
        n_vec++;
        if ({pc_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 4'b1111) begin
            n_err++; $display("FAIL b2b_sq2: got %b want 1111", {pc_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
        end
        @(negedge clk); br_taken_mem = 1'b0; #1;
        n_vec++;
        if ({pc_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3} !== 4'b1000) begin
            n_err++; $display("FAIL b2b_recover: got %b want 1000", {pc_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3});
        end
        @(negedge clk); #1;
        n_vec++;
        if (flush_cnt_3 !== (32'd3 & PERF_MASK)) begin
            n_err++; $display("FAIL b2b_flush_cnt: got %0d want %0d", flush_cnt_3, 32'd3 & PERF_MASK);
        end
    endtask

    task automatic test_hazard_qualifiers();
        pulse_reset();
        @(negedge clk); mem_read_ex = 1'b1; rw_ex = 5'd31; rn_id = 5'd31; rm_id = 5'd31; uses_rm_id = 1'b1; #1;
        n_vec++;
        if ({pc_en_1, pc_en_3} !== 2'b11) begin
            n_err++; $display("FAIL q_xzr: got %b want 11", {pc_en_1, pc_en_3});
        end
        @(negedge clk); rw_ex = 5'd4; rn_id = 5'd0; rm_id = 5'd4; uses_rm_id = 1'b0; #1;
        n_vec++;
        if ({pc_en_1, pc_en_3} !== 2'b11) begin
            n_err++; $display("FAIL q_no_rm: got %b want 11", {pc_en_1, pc_en_3});
        end
        @(negedge clk); mem_read_ex = 1'b0; rn_id = 5'd4; #1;
        n_vec++;
        if ({pc_en_1, pc_en_3} !== 2'b11) begin
            n_err++; $display("FAIL q_no_load: got %b want 11", {pc_en_1, pc_en_3});
        end
        @(negedge clk); mem_read_ex = 1'b1; rn_id = 5'd0; uses_rm_id = 1'b1; #1;
        n_vec++;
        if ({pc_en_1, id_ex_flush_1} !== 2'b01) begin
            n_err++; $display("FAIL q_rm_match: got %b want 01", {pc_en_1, id_ex_flush_1});
        end
        idle(4);
        @(negedge clk); mem_read_ex = 1'b1; rw_ex = 5'd5; rn_id = 5'd5; rm_id = 5'd5; uses_rm_id = 1'b1; #1;
        n_vec++;
        if (pc_en_1 !== 1'b0) begin
            n_err++; $display("FAIL q_both_stall: got %b want 0", pc_en_1);
        end
        @(negedge clk); clear_inputs(); #1;
        n_vec++;
        if ({pc_en_1, stall_cnt_1} !== {1'b1, 32'd2 & PERF_MASK}) begin
            n_err++; $display("FAIL q_both_single: got pc_en %b cnt %0d want 1 %0d", pc_en_1, stall_cnt_1, 32'd2 & PERF_MASK);
        end
        idle(3);
        #1;
        n_vec++;
        if (stall_cnt_3 !== (32'd6 & PERF_MASK)) begin
            n_err++; $display("FAIL q_dut3_cnt: got %0d want %0d", stall_cnt_3, 32'd6 & PERF_MASK);
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        regwrite_mem = 1'b1; rw_mem = 5'd7; regwrite_wb = 1'b1; rw_wb = 5'd7; rn_ex = 5'd7; rm_ex = 5'd9; #1;
        n_vec++;
        if ({fwd_a_3, fwd_b_3} !== 4'b1000) begin
            n_err++; $display("FAIL fwd_mem_wins: got %b want 1000", {fwd_a_3, fwd_b_3});
        end
        rw_mem = 5'd31; #1;
        n_vec++;
        if ({fwd_a_3, fwd_b_3} !== 4'b0100) begin
            n_err++; $display("FAIL fwd_mem_xzr: got %b want 0100", {fwd_a_3, fwd_b_3});
        end
        rm_ex = 5'd7; rw_mem = 5'd9; #1;
        n_vec++;
        if ({fwd_a_3, fwd_b_3} !== 4'b0101) begin
            n_err++; $display("FAIL fwd_b_wb: got %b want 0101", {fwd_a_3, fwd_b_3});
        end
        rm_ex = 5'd9; #1;
        n_vec++;
        if ({fwd_a_1, fwd_b_1} !== 4'b0110) begin
            n_err++; $display("FAIL fwd_b_mem: got %b want 0110", {fwd_a_1, fwd_b_1});
        end
        regwrite_mem = 1'b0; regwrite_wb = 1'b0; #1;
        n_vec++;
        if ({fwd_a_3, fwd_b_3} !== 4'b0000) begin
            n_err++; $display("FAIL fwd_no_wr: got %b want 0000", {fwd_a_3, fwd_b_3});
        end
        regwrite_mem = 1'b1; regwrite_wb = 1'b1; rw_mem = 5'd31; rw_wb = 5'd31; rn_ex = 5'd31; rm_ex = 5'd31; #1;
        n_vec++;
        if ({fwd_a_3, fwd_b_3} !== 4'b0000) begin
            n_err++; $display("FAIL fwd_xzr_both: got %b want 0000", {fwd_a_3, fwd_b_3});
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        pulse_reset();
        @(negedge clk); mem_read_ex = 1'b1; rw_ex = 5'd3; rn_id = 5'd3; #1;
        n_vec++;
        if (pc_en_3 !== 1'b0) begin
            n_err++; $display("FAIL rms_stall: got %b want 0", pc_en_3);
        end
        @(negedge clk); reset = 1'b0; clear_inputs(); regwrite_mem = 1'b1; rw_mem = 5'd7; rn_ex = 5'd7; #1;
        n_vec++;
        if ({pc_en_3, if_id_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3, fwd_a_3} !== 7'b0011100) begin
            n_err++; $display("FAIL rms_forced: got %b want 0011100",
                {pc_en_3, if_id_en_3, if_id_flush_3, id_ex_flush_3, ex_mem_flush_3, fwd_a_3});
        end
        @(negedge clk); reset = 1'b1; clear_inputs(); #1;
        n_vec++;
        if ({pc_en_3, if_id_en_3, id_ex_flush_3, stall_cnt_3} !== {3'b110, 32'd0}) begin
            n_err++; $display("FAIL rms_abandon: got %b cnt %0d want 110 cnt 0", {pc_en_3, if_id_en_3, id_ex_flush_3}, stall_cnt_3);
        end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_load_use_single();
        test_load_use_multi_branch();
        test_hazard_qualifiers();
        test_forwarding();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
